// File: rtl/dtw_mem_responder.sv
// dtw_mem_responder: SRAM-style responder for the DTW accelerator with host access port and result-set tracking
module dtw_mem_responder #(
  parameter int                ADDR_W   = 10,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 1024,
  parameter logic [ADDR_W-1:0] RES_BASE = 10'h3C0,
  parameter int                RES_LEN  = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              cs_i,
  input  logic              wr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              data_tri_ena_i,
  output logic [DATA_W-1:0] data_o,
  input  logic              host_req_i,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [DATA_W-1:0] host_wdata_i,
  output logic              host_gnt_o,
  output logic              host_rvalid_o,
  output logic [DATA_W-1:0] host_rdata_o,
  input  logic              res_clr_i,
  output logic [ADDR_W-1:0] res_cnt_o,
  output logic              res_done_o,
  output logic              res_irq_o,
  output logic              err_o
);
  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;
  localparam logic [ADDR_W-1:0] RES_LEN_C = ADDR_W'(RES_LEN);
  logic [DATA_W-1:0] mem [DEPTH];
  state_t state_q, state_d;
  logic acc_rd, acc_wr, bad_wr, host_wr, host_rd, res_wr, last, we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  always_comb begin
    acc_rd     = cs_i & ~wr_i;
    acc_wr     = cs_i & wr_i & data_tri_ena_i;
    bad_wr     = cs_i & wr_i & ~data_tri_ena_i;
    host_gnt_o = host_req_i & ~cs_i;
    host_wr    = host_gnt_o & host_we_i;
    host_rd    = host_gnt_o & ~host_we_i;
    res_wr     = acc_wr & (addr_i >= RES_BASE);
    last       = (res_cnt_o + 1'b1) == RES_LEN_C;
    we         = acc_wr | host_wr;
    waddr      = acc_wr ? addr_i : host_addr_i;
    wdata      = acc_wr ? data_i : host_wdata_i;
  end
  // The host is only granted while cs_i is low, so one shared write port suffices
  always_ff @(posedge clk_i)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      data_o        <= '0;
      host_rvalid_o <= 1'b0;
      host_rdata_o  <= '0;
      err_o         <= 1'b0;
    end else begin
      if (acc_rd) data_o <= mem[addr_i];
      host_rvalid_o <= host_rd;
      if (host_rd) host_rdata_o <= mem[host_addr_i];
      if (bad_wr) err_o <= 1'b1;
    end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) state_q <= IDLE;
    else state_q <= state_d;
  // Clear beats a coincident result write; the word is still stored but never counted
  always_comb
    state_d = res_clr_i ? IDLE :
              (res_wr && state_q != DONE) ? (last ? DONE : COLLECT) : state_q;
  always_comb
    res_done_o = state_q == DONE;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      res_cnt_o <= '0;
      res_irq_o <= 1'b0;
    end else begin
      res_cnt_o <= res_clr_i ? '0 : (res_wr && state_q != DONE) ? res_cnt_o + 1'b1 : res_cnt_o;
      res_irq_o <= state_d == DONE && state_q != DONE;
    end
endmodule

// File: tb/tb_dtw_mem_responder.sv
// tb_dtw_mem_responder: directed and randomized checks of dtw_mem_responder against a word-array/counter model
module tb_dtw_mem_responder;
  logic        clk_i = 0, rst_i = 0;
  logic [9:0]  addr_i, host_addr_i;
  logic        cs_i, wr_i, data_tri_ena_i, host_req_i, host_we_i, res_clr_i;
  logic [31:0] data_i, host_wdata_i;
  logic [31:0] data_o, host_rdata_o;
  logic        host_gnt_o, host_rvalid_o, res_done_o, res_irq_o, err_o;
  logic [9:0]  res_cnt_o;
  int checks = 0, failures = 0;
  logic [31:0] mem_m [1024];
  bit          known [1024];

  dtw_mem_responder dut (
    .clk_i(clk_i), .rst_i(rst_i), .addr_i(addr_i), .cs_i(cs_i), .wr_i(wr_i),
    .data_i(data_i), .data_tri_ena_i(data_tri_ena_i), .data_o(data_o),
    .host_req_i(host_req_i), .host_we_i(host_we_i), .host_addr_i(host_addr_i),
    .host_wdata_i(host_wdata_i), .host_gnt_o(host_gnt_o), .host_rvalid_o(host_rvalid_o),
    .host_rdata_o(host_rdata_o), .res_clr_i(res_clr_i), .res_cnt_o(res_cnt_o),
    .res_done_o(res_done_o), .res_irq_o(res_irq_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic clear_in();
    cs_i = 0; wr_i = 0; addr_i = '0; data_i = '0; data_tri_ena_i = 0;
    host_req_i = 0; host_we_i = 0; host_addr_i = '0; host_wdata_i = '0; res_clr_i = 0;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic host_write(input logic [9:0] a, input logic [31:0] d);
    host_req_i = 1; host_we_i = 1; host_addr_i = a; host_wdata_i = d;
    step();
    clear_in();
    mem_m[a] = d; known[a] = 1;
  endtask

  task automatic host_read(input logic [9:0] a);
    host_req_i = 1; host_we_i = 0; host_addr_i = a;
    step();
    clear_in();
  endtask

  task automatic acc_write(input logic [9:0] a, input logic [31:0] d, input logic te);
    cs_i = 1; wr_i = 1; addr_i = a; data_i = d; data_tri_ena_i = te;
    step();
    clear_in();
    if (te) begin mem_m[a] = d; known[a] = 1; end
  endtask

  task automatic acc_read(input logic [9:0] a);
    cs_i = 1; wr_i = 0; addr_i = a;
    step();
    clear_in();
  endtask

  task automatic test_reset();
    clear_in();
    #2;
    checks++;
    if ({data_o, host_rdata_o, host_rvalid_o, res_cnt_o, res_done_o, res_irq_o, err_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: data_o=%h rdata=%h rvalid=%b cnt=%0d done=%b irq=%b err=%b, all required 0",
               data_o, host_rdata_o, host_rvalid_o, res_cnt_o, res_done_o, res_irq_o, err_o);
    end
    @(negedge clk_i);
    rst_i = 1;
    step();
  endtask

  task automatic test_host_then_acc_read();
    host_write(10'd5, 32'hA5A5_0001);
    cs_i = 1; wr_i = 0; addr_i = 10'd5;
    #1;
    checks++;
    if (data_o === 32'hA5A5_0001) begin
      failures++;
      $display("FAIL t1_latency: data_o=%h before the read edge, expected previous value", data_o);
    end
    @(posedge clk_i); #1;
    clear_in();
    checks++;
    if (data_o !== 32'hA5A5_0001) begin
      failures++;
      $display("FAIL t1_read: data_o=%h required %h", data_o, 32'hA5A5_0001);
    end
  endtask

  task automatic test_arbitration();
    host_write(10'd3, 32'h0000_3333);
    cs_i = 1; wr_i = 0; addr_i = 10'd3;
    host_req_i = 1; host_we_i = 0; host_addr_i = 10'd5;
    #1;
    checks++;
    if (host_gnt_o !== 1'b0) begin
      failures++;
      $display("FAIL t2_gnt_blocked: host_gnt_o=%b required 0", host_gnt_o);
    end
    @(posedge clk_i); #1;
    cs_i = 0;
    checks++;
    if (data_o !== 32'h0000_3333 || host_rvalid_o !== 1'b0) begin
      failures++;
      $display("FAIL t2_acc_first: data_o=%h rvalid=%b required %h 0", data_o, host_rvalid_o, 32'h0000_3333);
    end
    #1;
    checks++;
    if (host_gnt_o !== 1'b1) begin
      failures++;
      $display("FAIL t2_gnt_idle: host_gnt_o=%b required 1", host_gnt_o);
    end
    @(posedge clk_i); #1;
    clear_in();
    checks++;
    if (host_rvalid_o !== 1'b1 || host_rdata_o !== 32'hA5A5_0001) begin
      failures++;
      $display("FAIL t2_rvalid: rvalid=%b rdata=%h required 1 %h", host_rvalid_o, host_rdata_o, 32'hA5A5_0001);
    end
    step();
    checks++;
    if (host_rvalid_o !== 1'b0 || host_rdata_o !== 32'hA5A5_0001) begin
      failures++;
      $display("FAIL t2_hold: rvalid=%b rdata=%h required 0 %h", host_rvalid_o, host_rdata_o, 32'hA5A5_0001);
    end
  endtask

  task automatic test_result_collect();
    int irqs = 0;
    for (int i = 0; i < 64; i++) begin
      acc_write(10'h3C0 + 10'(i), $urandom, 1'b1);
      irqs += int'(res_irq_o);
      checks++;
      if (res_cnt_o !== 10'(i + 1) || res_done_o !== (i == 63) || res_irq_o !== (i == 63)) begin
        failures++;
        $display("FAIL t3_count[%0d]: cnt=%0d done=%b irq=%b required %0d %b %b",
                 i, res_cnt_o, res_done_o, res_irq_o, i + 1, i == 63, i == 63);
      end
    end
    step();
    checks++;
    if (res_irq_o !== 1'b0 || res_done_o !== 1'b1 || irqs != 1) begin
      failures++;
      $display("FAIL t3_after: irq=%b done=%b irq_pulses=%0d required 0 1 1", res_irq_o, res_done_o, irqs);
    end
    for (int i = 0; i < 64; i++) begin
      host_read(10'h3C0 + 10'(i));
      checks++;
      if (host_rvalid_o !== 1'b1 || host_rdata_o !== mem_m[10'h3C0 + i]) begin
        failures++;
        $display("FAIL t3_readback[%0d]: rvalid=%b rdata=%h required 1 %h", i, host_rvalid_o, host_rdata_o, mem_m[10'h3C0 + i]);
      end
    end
  endtask

  task automatic test_done_overflow();
    acc_write(10'h3C5, 32'hDEAD_0065, 1'b1);
    checks++;
    if (res_cnt_o !== 10'd64 || res_irq_o !== 1'b0 || res_done_o !== 1'b1) begin
      failures++;
      $display("FAIL t4_sat: cnt=%0d irq=%b done=%b required 64 0 1", res_cnt_o, res_irq_o, res_done_o);
    end
    host_read(10'h3C5);
    checks++;
    if (host_rdata_o !== 32'hDEAD_0065) begin
      failures++;
      $display("FAIL t4_stored: rdata=%h required %h", host_rdata_o, 32'hDEAD_0065);
    end
    res_clr_i = 1;
    step();
    clear_in();
    checks++;
    if (res_cnt_o !== 10'd0 || res_done_o !== 1'b0 || res_irq_o !== 1'b0) begin
      failures++;
      $display("FAIL t4_clear: cnt=%0d done=%b irq=%b required 0 0 0", res_cnt_o, res_done_o, res_irq_o);
    end
    res_clr_i = 1;
    acc_write(10'h3C1, 32'h0C1E_A000, 1'b1);
    checks++;
    if (res_cnt_o !== 10'd0 || res_irq_o !== 1'b0) begin
      failures++;
      $display("FAIL t4_clear_wins: cnt=%0d irq=%b required 0 0", res_cnt_o, res_irq_o);
    end
    acc_write(10'h3C2, 32'h0000_0002, 1'b1);
    checks++;
    if (res_cnt_o !== 10'd1 || res_done_o !== 1'b0) begin
      failures++;
      $display("FAIL t4_restart: cnt=%0d done=%b required 1 0", res_cnt_o, res_done_o);
    end
    acc_write(10'h010, 32'h0000_0010, 1'b1);
    checks++;
    if (res_cnt_o !== 10'd1) begin
      failures++;
      $display("FAIL t4_template_uncounted: cnt=%0d required 1", res_cnt_o);
    end
    host_write(10'h3C3, 32'h0000_0003);
    checks++;
    if (res_cnt_o !== 10'd1) begin
      failures++;
      $display("FAIL t4_host_uncounted: cnt=%0d required 1", res_cnt_o);
    end
    acc_read(10'h3C1);
    checks++;
    if (data_o !== 32'h0C1E_A000) begin
      failures++;
      $display("FAIL t4_clear_stored: data_o=%h required %h", data_o, 32'h0C1E_A000);
    end
  endtask

  task automatic test_err();
    host_write(10'd7, 32'h7777_0007);
    checks++;
    if (err_o !== 1'b0) begin
      failures++;
      $display("FAIL t5_err_clean: err=%b required 0", err_o);
    end
    acc_write(10'd7, 32'hBAD0_BAD0, 1'b0);
    checks++;
    if (err_o !== 1'b1) begin
      failures++;
      $display("FAIL t5_err_set: err=%b required 1", err_o);
    end
    acc_read(10'd7);
    repeat (3) step();
    checks++;
    if (data_o !== 32'h7777_0007 || err_o !== 1'b1) begin
      failures++;
      $display("FAIL t5_unchanged: data_o=%h err=%b required %h 1", data_o, err_o, 32'h7777_0007);
    end
  endtask

  task automatic test_reset_mid();
    host_write(10'd20, 32'h1234_5678);
    acc_read(10'd20);
    acc_write(10'h3D0, 32'h1, 1'b1);
    acc_write(10'h3D1, 32'h2, 1'b1);
    checks++;
    if (data_o !== 32'h1234_5678 || res_cnt_o !== 10'd3) begin
      failures++;
      $display("FAIL t6_pre: data_o=%h cnt=%0d required %h 3", data_o, res_cnt_o, 32'h1234_5678);
    end
    cs_i = 1; wr_i = 0; addr_i = 10'd7;
    host_req_i = 1; host_addr_i = 10'd20;
    #2 rst_i = 0;
    #1;
    checks++;
    if (data_o !== '0 || res_cnt_o !== '0 || res_done_o !== 1'b0 || err_o !== 1'b0) begin
      failures++;
      $display("FAIL t6_async: data_o=%h cnt=%0d done=%b err=%b required all 0", data_o, res_cnt_o, res_done_o, err_o);
    end
    @(posedge clk_i); #1;
    clear_in();
    @(negedge clk_i);
    rst_i = 1;
    step();
    checks++;
    if (data_o !== '0 || host_rvalid_o !== 1'b0 || host_rdata_o !== '0) begin
      failures++;
      $display("FAIL t6_dropped: data_o=%h rvalid=%b rdata=%h required 0 0 0", data_o, host_rvalid_o, host_rdata_o);
    end
    host_read(10'd20);
    checks++;
    if (host_rdata_o !== 32'h1234_5678 || host_rvalid_o !== 1'b1) begin
      failures++;
      $display("FAIL t6_template_kept: rdata=%h rvalid=%b required %h 1", host_rdata_o, host_rvalid_o, 32'h1234_5678);
    end
    acc_write(10'h3E0, 32'h3E0, 1'b1);
    checks++;
    if (res_cnt_o !== 10'd1) begin
      failures++;
      $display("FAIL t6_idle_restart: cnt=%0d required 1", res_cnt_o);
    end
  endtask

  task automatic test_random();
    int cnt_m = 1;
    bit err_m = 0, irq_m;
    logic [31:0] dexp, rexp;
    bit dknown = 0, rknown = 0, rv_m;
    logic [9:0] a;
    for (int n = 0; n < 600; n++) begin
      int op = $urandom_range(0, 9);
      clear_in();
      a = ($urandom_range(0, 1) == 1) ? 10'h3C0 + 10'($urandom_range(0, 63)) : 10'($urandom_range(0, 31));
      addr_i = a;
      if (op < 3) cs_i = 1;
      else if (op < 7) begin
        cs_i = 1; wr_i = 1; data_i = $urandom; data_tri_ena_i = $urandom_range(0, 15) != 0;
      end
      host_req_i = $urandom_range(0, 1);
      host_we_i = $urandom_range(0, 1);
      host_addr_i = ($urandom_range(0, 1) == 1) ? 10'h3C0 + 10'($urandom_range(0, 63)) : 10'($urandom_range(0, 31));
      host_wdata_i = $urandom;
      res_clr_i = $urandom_range(0, 40) == 0;
      #1;
      checks++;
      if (host_gnt_o !== (host_req_i & ~cs_i)) begin
        failures++;
        $display("FAIL rnd_gnt[%0d]: gnt=%b required %b", n, host_gnt_o, host_req_i & ~cs_i);
      end
      if (cs_i && !wr_i) begin dknown = known[a]; dexp = mem_m[a]; end
      rv_m = host_req_i && !cs_i && !host_we_i;
      if (rv_m) begin rknown = known[host_addr_i]; rexp = mem_m[host_addr_i]; end
      if (cs_i && wr_i && !data_tri_ena_i) err_m = 1;
      if (cs_i && wr_i && data_tri_ena_i) begin mem_m[a] = data_i; known[a] = 1; end
      if (host_req_i && !cs_i && host_we_i) begin mem_m[host_addr_i] = host_wdata_i; known[host_addr_i] = 1; end
      irq_m = 0;
      if (res_clr_i) cnt_m = 0;
      else if (cs_i && wr_i && data_tri_ena_i && a >= 10'h3C0 && cnt_m < 64) begin
        cnt_m++;
        irq_m = cnt_m == 64;
      end
      @(posedge clk_i); #1;
      checks++;
      if ((dknown && data_o !== dexp) || host_rvalid_o !== rv_m || (rknown && host_rdata_o !== rexp)) begin
        failures++;
        $display("FAIL rnd_data[%0d]: data_o=%h rvalid=%b rdata=%h required %h %b %h", n, data_o, host_rvalid_o, host_rdata_o, dexp, rv_m, rexp);
      end
      checks++;
      if (res_cnt_o !== 10'(cnt_m) || res_done_o !== (cnt_m == 64) || res_irq_o !== irq_m || err_o !== err_m) begin
        failures++;
        $display("FAIL rnd_res[%0d]: cnt=%0d done=%b irq=%b err=%b required %0d %b %b %b",
                 n, res_cnt_o, res_done_o, res_irq_o, err_o, cnt_m, cnt_m == 64, irq_m, err_m);
      end
    end
    clear_in();
  endtask

  initial begin
    test_reset();
    test_host_then_acc_read();
    test_arbitration();
    test_result_collect();
    test_done_overflow();
    test_err();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
